// File: rtl/step_gen_pkg.sv
// Shared state encoding and default timing constants for the STEP/DIR pulse generator.
package step_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_t;

  // Defaults give 5 us STEP high/low and 2 us DIR setup at 100 MHz.
  localparam int unsigned DEF_PULSE_HIGH_CYCLES = 500;
  localparam int unsigned DEF_PULSE_LOW_CYCLES  = 500;
  localparam int unsigned DEF_DIR_SETUP_CYCLES  = 200;
  localparam int unsigned DEF_CNT_WIDTH         = 16;
  localparam int unsigned DEF_POS_WIDTH         = 32;

endpackage

// File: rtl/step_interval_timer.sv
// Loadable down-counter shared by the DIR-setup, STEP-high and STEP-low intervals.
module step_interval_timer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 expired_c
);

  logic [CNT_WIDTH-1:0] tmr;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (load) begin
      tmr <= load_value;
    end else if (tmr != '0) begin
      tmr <= tmr - CNT_WIDTH'(1);
    end
  end

  // An interval of N cycles is loaded as N-1 and ends on the cycle it reads zero.
  assign expired_c = (tmr == '0);

endmodule

// File: rtl/step_pulse_generator.sv
// Turns one-cycle step requests into STEP/DIR pin drive with guaranteed pulse
// widths and DIR setup time, and keeps a wrapping signed position count.
module step_pulse_generator
  import step_gen_pkg::*;
#(
  parameter int unsigned PULSE_HIGH_CYCLES = DEF_PULSE_HIGH_CYCLES,
  parameter int unsigned PULSE_LOW_CYCLES  = DEF_PULSE_LOW_CYCLES,
  parameter int unsigned DIR_SETUP_CYCLES  = DEF_DIR_SETUP_CYCLES,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH,
  parameter int unsigned POS_WIDTH         = DEF_POS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 step_req,
  input  logic                 step_dir,
  output logic                 step_ready,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 busy,
  output logic [POS_WIDTH-1:0] position,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam logic [CNT_WIDTH-1:0] HIGH_LOAD  = CNT_WIDTH'(PULSE_HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOW_LOAD   = CNT_WIDTH'(PULSE_LOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(DIR_SETUP_CYCLES - 1);

  step_state_t          state;
  logic                 accept;
  logic                 tmr_load;
  logic [CNT_WIDTH-1:0] tmr_load_value;
  logic                 tmr_expired;

  assign accept = (state == ST_IDLE) && step_req && step_ready;

  step_interval_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .expired_c  (tmr_expired)
  );

  // Timer reload for the interval the FSM is about to enter.
  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load       = 1'b1;
          tmr_load_value = (step_dir != dir_out) ? SETUP_LOAD : HIGH_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          tmr_load       = 1'b1;
          tmr_load_value = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (tmr_expired) begin
          tmr_load       = 1'b1;
          tmr_load_value = LOW_LOAD;
        end
      end
      default: begin
        tmr_load       = 1'b0;
        tmr_load_value = '0;
      end
    endcase
  end

  // Pulse FSM with registered pin drive, handshake, position and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step_out   <= 1'b0;
      dir_out    <= 1'b0;
      busy       <= 1'b0;
      position   <= '0;
      overrun    <= 1'b0;
      step_ready <= 1'b0;
    end else begin
      // A request that is not accepted is dropped; setting beats clearing.
      if (step_req && !step_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      step_ready <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (step_dir != dir_out) begin
              dir_out <= step_dir;
              state   <= ST_SETUP;
            end else begin
              step_out <= 1'b1;
              state    <= ST_HIGH;
            end
          end else begin
            step_ready <= enable;
          end
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            step_out <= 1'b1;
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tmr_expired) begin
            step_out <= 1'b0;
            position <= dir_out ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tmr_expired) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Scoreboard bench for step_pulse_generator: each issued step pushes its expected
// pulse (rise latency, DIR level, period, final position); a monitor checks pulses.
module tb_step_pulse_generator;

  localparam int unsigned PH = 4;
  localparam int unsigned PL = 3;
  localparam int unsigned DS = 2;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          step_req;
  logic          step_dir;
  logic          step_ready;
  logic          step_out;
  logic          dir_out;
  logic          busy;
  logic [PW-1:0] position;
  logic          overrun;
  logic          clear_overrun;

  typedef struct {
    logic          dir;
    int            lat;
    logic [PW-1:0] pos;
    int            period;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] model_pos = '0;
  logic          model_dir = 1'b0;

  step_pulse_generator #(
    .PULSE_HIGH_CYCLES (PH),
    .PULSE_LOW_CYCLES  (PL),
    .DIR_SETUP_CYCLES  (DS),
    .CNT_WIDTH         (16),
    .POS_WIDTH         (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .step_req      (step_req),
    .step_dir      (step_dir),
    .step_ready    (step_ready),
    .step_out      (step_out),
    .dir_out       (dir_out),
    .busy          (busy),
    .position      (position),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for step_ready, record the expected pulse, then present a one-cycle request.
  task automatic issue(input logic dir, input int period);
    exp_t r;
    int   w = 0;
    while (!step_ready && w < 100) begin
      cyc(1);
      w++;
    end
    if (!step_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: step_ready still 0 after %0d cycles", w);
      return;
    end
    r.dir     = dir;
    r.lat     = (dir != model_dir) ? int'(1 + DS) : 1;
    model_dir = dir;
    model_pos = dir ? model_pos + PW'(1) : model_pos - PW'(1);
    r.pos     = model_pos;
    r.period  = period;
    sb_q.push_back(r);
    step_req = 1'b1;
    step_dir = dir;
    cyc(1);
    step_req = 1'b0;
  endtask

  // Wait until every expected pulse has been seen and the FSM is back in IDLE.
  task automatic drain();
    int w = 0;
    while ((sb_q.size() != 0 || busy) && w < 300) begin
      cyc(1);
      w++;
    end
    if (sb_q.size() != 0 || busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d pulses outstanding, busy=%0b", sb_q.size(), busy);
    end
  endtask

  // Pulse monitor: checks rise latency, DIR, period on rising edges; width and position on falls.
  int   mon_cyc   = 0;
  int   acc_cyc   = 0;
  int   rise_cyc  = 0;
  int   hi_len    = 0;
  logic prev_step = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    mon_cyc++;
    if (rst) begin
      prev_step = 1'b0;
      hi_len    = 0;
    end else begin
      if (step_req && step_ready) acc_cyc = mon_cyc;
      if (step_out && !prev_step) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rise", 32'(1), 32'(0));
        end else begin
          mon_e = sb_q[0];
          chk("rise_latency", 32'(mon_cyc - acc_cyc), 32'(mon_e.lat));
          chk("dir_at_rise", 32'(dir_out), 32'(mon_e.dir));
          if (mon_e.period != 0) chk("step_period", 32'(mon_cyc - rise_cyc), 32'(mon_e.period));
        end
        rise_cyc = mon_cyc;
        hi_len   = 0;
      end
      if (step_out) hi_len++;
      if (!step_out && prev_step) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_fall", 32'(1), 32'(0));
        end else begin
          mon_e = sb_q.pop_front();
          chk("high_width", 32'(hi_len), 32'(PH));
          chk("position_after_fall", 32'(position), 32'(mon_e.pos));
        end
      end
      prev_step = step_out;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    enable        = 1'b0;
    step_req      = 1'b0;
    step_dir      = 1'b0;
    clear_overrun = 1'b0;
    cyc(3);
    chk("rst_step_out", 32'(step_out), 32'(0));
    chk("rst_dir_out", 32'(dir_out), 32'(0));
    chk("rst_position", 32'(position), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_step_ready", 32'(step_ready), 32'(0));
    rst    = 1'b0;
    enable = 1'b1;

    // 1: minus step with no DIR change, then the re-arm delay.
    issue(1'b0, 0);
    chk("t1_step_high_now", 32'(step_out), 32'(1));
    n = 0;
    while (step_out && n < 20) begin cyc(1); n++; end
    chk("t1_high_cycles", 32'(n), 32'(4));
    n = 0;
    while (!step_ready && n < 20) begin cyc(1); n++; end
    chk("t1_ready_after_fall", 32'(n), 32'(4));
    chk("t1_position", 32'(position), 32'h0000_00FF);

    // 2: DIR change inserts setup before the rise.
    issue(1'b1, 0);
    chk("t2_dir_next_edge", 32'(dir_out), 32'(1));
    chk("t2_step_still_low", 32'(step_out), 32'(0));
    drain();
    chk("t2_position", 32'(position), 32'h0000_0000);

    // 3: requests during the pulse are dropped; set beats clear.
    issue(1'b1, 0);
    step_req = 1'b1;
    cyc(1);
    chk("t3_overrun_set", 32'(overrun), 32'(1));
    clear_overrun = 1'b1;
    cyc(1);
    chk("t3_set_beats_clear", 32'(overrun), 32'(1));
    step_req = 1'b0;
    cyc(1);
    chk("t3_overrun_cleared", 32'(overrun), 32'(0));
    clear_overrun = 1'b0;
    drain();
    chk("t3_position", 32'(position), 32'h0000_0001);

    // 4: back-to-back accepts give a 9-cycle STEP period.
    issue(1'b1, 0);
    issue(1'b1, 9);
    issue(1'b1, 9);
    issue(1'b1, 9);
    drain();
    chk("t4_position", 32'(position), 32'h0000_0005);

    // 5a: reset in HIGH truncates the pulse.
    issue(1'b1, 0);
    cyc(1);
    chk("t5_in_high", 32'(step_out), 32'(1));
    sb_q.delete();
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_step_out", 32'(step_out), 32'(0));
    chk("t5_rst_position", 32'(position), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    cyc(1);
    rst       = 1'b0;
    model_pos = '0;
    model_dir = 1'b0;

    // 5b: dropping enable mid-pulse lets the pulse finish, then blocks accepts.
    issue(1'b0, 0);
    enable = 1'b0;
    drain();
    cyc(2);
    chk("t5_ready_disabled", 32'(step_ready), 32'(0));
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(3);
    chk("t5_drop_overrun", 32'(overrun), 32'(1));
    chk("t5_drop_no_step", 32'(step_out), 32'(0));
    chk("t5_drop_position", 32'(position), 32'h0000_00FF);
    clear_overrun = 1'b1;
    cyc(1);
    clear_overrun = 1'b0;
    enable        = 1'b1;

    // 6: wrap through max-positive and all the way around from zero.
    rst = 1'b1;
    cyc(2);
    rst       = 1'b0;
    model_pos = '0;
    model_dir = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      issue(1'b1, 0);
      if (i == 127) begin
        drain();
        chk("t6_pos_7f", 32'(position), 32'h0000_007F);
      end
      if (i == 128) begin
        drain();
        chk("t6_pos_80", 32'(position), 32'h0000_0080);
      end
    end
    drain();
    chk("t6_pos_wrap_00", 32'(position), 32'h0000_0000);
    chk("t6_no_overrun", 32'(overrun), 32'(0));

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
